param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, 8: COUNT, MAX and LOAD_VAL width in bits (>=2).
REQ-002 Parameter PRE_WIDTH, 4: PRESCALE width in bits (>=1).
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 EN  input  1  count enable; low SHALL freeze the prescaler and COUNT.
REQ-006 CLR  input  1  synchronous clear.
REQ-007 LOAD  input  1  synchronous load of LOAD_VAL.
REQ-008 LOAD_VAL  input  WIDTH  load value.
REQ-009 DIR  input  1  1 = count up, 0 = count down.
REQ-010 MODE  input  1  0 = wrap, 1 = saturate.
REQ-011 MAX  input  WIDTH  terminal value for up-counting; count range 0..MAX.
REQ-012 PRESCALE  input  PRE_WIDTH  one tick every PRESCALE+1 enabled cycles.
REQ-013 COUNT  output  WIDTH  registered count value.
REQ-014 TC  output  1  registered one-cycle terminal-count pulse.
REQ-015 OUT  output  1  registered toggle output; inverts on every TC pulse.

Function
REQ-016 Prescaler SHALL count enabled cycles 0..PRESCALE; tick SHALL be asserted combinationally when EN=1 and prescaler==PRESCALE, and the prescaler SHALL then return to 0.
REQ-017 PRESCALE=0 SHALL produce a tick on every cycle with EN=1 (zero added latency: COUNT changes on the same edge EN is sampled high).
REQ-018 Priority per edge SHALL be CLR > LOAD > tick; CLR sets COUNT=0, LOAD sets COUNT=LOAD_VAL, and both SHALL reset the prescaler to 0 regardless of EN.
REQ-019 Up tick: COUNT<MAX -> COUNT+1; COUNT>=MAX -> 0 (wrap) or MAX (saturate).
REQ-020 Down tick: COUNT>0 -> COUNT-1; COUNT==0 -> MAX (wrap) or 0 (saturate).
REQ-021 Comparisons SHALL use the current MAX, DIR and MODE inputs each cycle; mid-count changes take effect on the next tick.
REQ-022 LOAD_VAL>MAX SHALL be loaded unchanged; subsequent behaviour follows REQ-019/REQ-020.
REQ-023 TC SHALL be 1 for exactly the cycle following an edge on which a tick changed COUNT to the terminal value (MAX when up, 0 when down); otherwise 0.
REQ-024 In saturate mode, a tick that leaves COUNT unchanged at the terminal value SHALL NOT pulse TC.
REQ-025 CLR or LOAD SHALL never pulse TC, even if the resulting value is terminal.
REQ-026 OUT SHALL toggle on the same edge that sets TC=1.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH internally, with no carry beyond WIDTH bits.

Reset
REQ-028 RST=1 SHALL immediately, without a clock edge, force COUNT=0, TC=0, OUT=0 and prescaler=0.
REQ-029 Outputs SHALL hold reset values while RST=1 regardless of other inputs.
REQ-030 The first tick after RST deassertion SHALL occur PRESCALE+1 enabled cycles later.

Structure
REQ-031 Package counter_pkg SHALL hold the DIR encodings (DIR_DOWN=0, DIR_UP=1), the MODE encodings (MODE_WRAP=0, MODE_SAT=1) and the default WIDTH/PRE_WIDTH constants.
REQ-032 The prescaler SHALL be a separate sub-module, counter_prescaler (ports CLK, RST, EN, CLR, PRESCALE, TICK), with CLR driven by CLR|LOAD.

Verification (WIDTH=8, PRE_WIDTH=4)
REQ-033 RST high 3 cycles with EN=1 -> COUNT=0, TC=0, OUT=0 throughout; after release with MAX=5, up, wrap, PRESCALE=0 -> COUNT 1,2,3,4,5,0,1; TC high only in the cycle after COUNT becomes 5; OUT toggles every 6 ticks.
REQ-034 LOAD with LOAD_VAL=3, then down, saturate -> COUNT 2,1,0,0,0; exactly one TC pulse.
REQ-035 PRESCALE=2 -> COUNT increments every 3rd cycle; EN low for 2 cycles mid-period delays the next tick by exactly 2 cycles.
REQ-036 CLR+LOAD+tick on the same edge -> COUNT=0; LOAD+tick -> COUNT=LOAD_VAL; neither pulses TC.
REQ-037 LOAD_VAL=200, MAX=10, up: wrap -> next tick COUNT=0 with no TC; saturate -> COUNT=10 with a TC pulse.
REQ-038 RST asserted between edges at COUNT=7 -> COUNT=0 before the next rising edge of CLK.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings and default sizes for the parameterised counter.
// Imported by counter_prescaler and param_counter.
package counter_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_PRE_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: counts enabled cycles 0..PRESCALE and emits a
// combinational TICK on the last one.
// Ports: CLK, RST (async, high), EN, CLR (sync), PRESCALE, TICK.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic [PRE_WIDTH-1:0] PRESCALE,
  output logic                 TICK
);

  logic [PRE_WIDTH-1:0] cnt;

  // PRESCALE=0 ticks on every enabled cycle with no added latency.
  assign TICK = EN && (cnt == PRESCALE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (TICK) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/param_counter.sv
// Up/down counter with wrap/saturate, prescaler, TC pulse, OUT toggle.
// Ports: CLK, RST, EN, CLR, LOAD, LOAD_VAL, DIR, MODE, MAX, PRESCALE
//        in; COUNT, TC, OUT registered out.
module param_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic                 LOAD,
  input  logic [WIDTH-1:0]     LOAD_VAL,
  input  logic                 DIR,
  input  logic                 MODE,
  input  logic [WIDTH-1:0]     MAX,
  input  logic [PRE_WIDTH-1:0] PRESCALE,
  output logic [WIDTH-1:0]     COUNT,
  output logic                 TC,
  output logic                 OUT
);

  logic             tick;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] term;
  logic             hit;

  counter_prescaler #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_pre (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .CLR     (CLR | LOAD),
    .PRESCALE(PRESCALE),
    .TICK    (tick)
  );

  always_comb begin
    nxt  = COUNT;
    term = '0;
    if (DIR == DIR_UP) begin
      term = MAX;
      if (COUNT < MAX) begin
        nxt = COUNT + 1'b1;
      end else begin
        nxt = (MODE == MODE_SAT) ? MAX : '0;
      end
    end else begin
      term = '0;
      if (COUNT != '0) begin
        nxt = COUNT - 1'b1;
      end else begin
        nxt = (MODE == MODE_SAT) ? '0 : MAX;
      end
    end
  end

  // Only a tick that actually moves COUNT onto the terminal counts;
  // a saturated hold at the terminal does not re-fire.
  assign hit = tick && (nxt == term) && (nxt != COUNT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COUNT <= '0;
      TC    <= 1'b0;
      OUT   <= 1'b0;
    end else if (CLR) begin
      COUNT <= '0;
      TC    <= 1'b0;
    end else if (LOAD) begin
      COUNT <= LOAD_VAL;
      TC    <= 1'b0;
    end else begin
      TC <= hit;
      if (tick) begin
        COUNT <= nxt;
      end
      if (hit) begin
        OUT <= ~OUT;
      end
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: directed scenarios then
// random stimulus against a behavioural reference model.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       dir;
  logic       mode;
  logic [7:0] max;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tc;
  logic       out;

  param_counter #(
    .WIDTH    (8),
    .PRE_WIDTH(4)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .EN      (en),
    .CLR     (clr),
    .LOAD    (load),
    .LOAD_VAL(load_val),
    .DIR     (dir),
    .MODE    (mode),
    .MAX     (max),
    .PRESCALE(prescale),
    .COUNT   (count),
    .TC      (tc),
    .OUT     (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int t;
    int o;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   run         = 0;

  int m_cnt = 0;
  int m_pre = 0;
  int m_tc  = 0;
  int m_out = 0;

  // Reference: integer model of the behaviour rules.
  task automatic step();
    exp_t e;
    int   nx;
    int   term;
    bit   tk;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_tc = 0; m_out = 0;
    end else begin
      tk = en && (m_pre == int'(prescale));
      if (clr || load) m_pre = 0;
      else if (tk) m_pre = 0;
      else if (en) m_pre = (m_pre + 1) % 16;
      if (clr) begin
        m_cnt = 0; m_tc = 0;
      end else if (load) begin
        m_cnt = int'(load_val); m_tc = 0;
      end else if (tk) begin
        if (dir) begin
          term = int'(max);
          if (m_cnt < int'(max)) nx = m_cnt + 1;
          else nx = mode ? int'(max) : 0;
        end else begin
          term = 0;
          if (m_cnt > 0) nx = m_cnt - 1;
          else nx = mode ? 0 : int'(max);
        end
        m_tc = (nx == term && nx != m_cnt) ? 1 : 0;
        if (m_tc == 1) m_out = 1 - m_out;
        m_cnt = nx;
      end else begin
        m_tc = 0;
      end
    end
    e.c = m_cnt; e.t = m_tc; e.o = m_out;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: pops one expectation per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (run) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: no expectation queued at %0t", $time);
        end else begin
          e = q.pop_front();
          if (int'(count) != e.c || int'(tc) != e.t || int'(out) != e.o) begin
            miscompares++;
            $display("FAIL cycle@%0t: count=%0d tc=%0d out=%0d expected %0d %0d %0d",
                     $time, count, tc, out, e.c, e.t, e.o);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; en = 1; clr = 0; load = 0; load_val = 0;
    dir = 1; mode = 0; max = 5; prescale = 0;
    #1;
    chk("reset_async_count", int'(count), 0);
    chk("reset_async_out", int'(out), 0);
    @(negedge clk);
    run = 1;
    // reset held with EN high, then 1..5,0,1,2 with wrap
    repeat (3) step();
    rst = 0;
    repeat (6) step();
    chk("wrap_to_zero", int'(count), 0);
    repeat (14) step();
    // load 3, down, saturate
    load = 1; load_val = 3; dir = 0; mode = 1;
    step();
    load = 0;
    repeat (5) step();
    chk("down_sat_zero", int'(count), 0);
    // prescale 2 with EN gap
    clr = 1; dir = 1; mode = 0; max = 200; prescale = 2;
    step();
    clr = 0;
    repeat (4) step();
    en = 0;
    repeat (2) step();
    en = 1;
    repeat (7) step();
    // CLR+LOAD+tick, LOAD+tick, LOAD of terminal value
    prescale = 0; max = 5;
    clr = 1; load = 1; load_val = 9;
    step();
    chk("clr_over_load", int'(count), 0);
    clr = 0; load = 1; load_val = 4;
    step();
    chk("load_over_tick", int'(count), 4);
    load_val = 5;
    step();
    chk("load_term_no_tc", int'(tc), 0);
    load = 0;
    step();
    // LOAD_VAL above MAX
    max = 10; mode = 0; load = 1; load_val = 200;
    step();
    load = 0;
    step();
    chk("above_max_wrap", int'(count), 0);
    chk("above_max_wrap_tc", int'(tc), 0);
    mode = 1; load = 1;
    step();
    load = 0;
    step();
    chk("above_max_sat", int'(count), 10);
    chk("above_max_sat_tc", int'(tc), 1);
    step();
    // async reset between edges at COUNT=7
    max = 20; mode = 0; clr = 1;
    step();
    clr = 0;
    repeat (7) step();
    chk("pre_async_count", int'(count), 7);
    #2;
    rst = 1;
    #1;
    chk("async_reset_count", int'(count), 0);
    step();
    rst = 0;
    repeat (3) step();
    // random phase
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 14) == 0);
      en   = ($urandom_range(0, 9) < 8);
      load_val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 39) == 0)
        max = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0)
        prescale = 4'($urandom_range(0, 3));
      step();
    end
    rst = 0; clr = 0; load = 0;
    run = 0;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
